pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator; successor to the single-register PC in the fetch stage. Each cycle it selects the next fetch address from one of four sources: hold, sequential increment, redirect target, or an optional return-address stack (RAS). Its `pc` output drives instruction-memory address and the IF/ID pipeline register. Hazard, branch and jump inputs come from the decode/execute stages.

## Interface
- `ADDR_W`, 18: PC width in bits.
- `INC`, 4: sequential increment in bytes; must be a power of two.
- `RESET_PC`, 0: value loaded on reset.
- `RAS_DEPTH`, 4: number of RAS entries; must be a power of two and at least 2.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `stall` input 1: hold the PC; from the hazard unit.
- `redirect_valid` input 1: branch taken or jump; next PC is `redirect_pc`.
- `redirect_pc` input ADDR_W: target for redirect and call.
- `call_valid` input 1: jump to `redirect_pc` and push `pc+INC`.
- `ret_valid` input 1: next PC is the RAS top; pop.
- `pc` output ADDR_W: current fetch address.
- `pc_valid` output 1: `pc` is a legal fetch address this cycle.
- `ras_empty` output 1: RAS holds 0 entries.
- `ras_full` output 1: RAS holds RAS_DEPTH entries.
- `ras_overflow` output 1: sticky; set when a push overwrote the oldest entry.
- `ret_underflow` output 1: one-cycle pulse when a ret was seen with the RAS empty.

## Operation
- **Reset** (`rst`=1 at a clock edge):
  - `pc`=RESET_PC, `pc_valid`=0.
  - RAS count=0, `ras_empty`=1, `ras_full`=0, `ras_overflow`=0, `ret_underflow`=0.
- **pc_valid:** goes to 1 on the first edge with `rst`=0. It then stays 1 until the next reset.
- **Next-PC priority**, highest first:
  1. `redirect_valid`: next PC = `redirect_pc`. This wins even when `stall`=1, because resolution flushes fetch. No RAS change.
  2. `stall`: PC held. `call_valid` and `ret_valid` are ignored, and the RAS is unchanged.
  3. `ret_valid` with RAS not empty: next PC = top entry; pop.
  4. `call_valid`: next PC = `redirect_pc`; push `pc+INC`.
  5. Otherwise: next PC = `pc+INC`.
- **call_valid and ret_valid together** (no stall, no redirect):
  - Next PC = `redirect_pc`.
  - The top entry is replaced by `pc+INC`; count is unchanged.
  - If the RAS is empty, this acts as a plain call.
- **ret_valid with the RAS empty:** next PC = `pc+INC`, `ret_underflow`=1 for one cycle, RAS unchanged.
- **Push when full:** the oldest entry is overwritten (circular), count stays RAS_DEPTH, and `ras_overflow` is set. It is cleared only by reset.
- **Arithmetic:**
  - `pc+INC` is computed modulo 2^ADDR_W. 2^ADDR_W−INC wraps to 0.
  - The low log2(INC) bits of `redirect_pc` are forced to 0 before loading.
- **Internal selection state** (pc_sel): SEL_HOLD, SEL_SEQ, SEL_REDIR, SEL_RAS. Derived combinationally each cycle from the priority list; no multi-cycle FSM beyond the reset/valid flag.

## Timing
- One-cycle latency: inputs sampled at edge N determine `pc` after edge N.
- `pc`, `pc_valid`, `ras_empty`, `ras_full` and `ras_overflow` are registered outputs.
- `ret_underflow` is registered and asserted for exactly the cycle after the offending edge.
- Control inputs are level-sampled. No handshake; a request held for k unstalled cycles acts k times.
- Reset mid-operation discards all RAS contents in the same edge.

## Configuration
- **`PC_GEN_RAS_EN` defined:** RAS present, with behaviour as above.
- **`PC_GEN_RAS_EN` undefined:**
  - No RAS storage.
  - `call_valid` behaves exactly as `redirect_valid`, without the stall override.
  - `ret_valid` is ignored, and next PC is sequential.
  - `ras_empty`=1; `ras_full`, `ras_overflow` and `ret_underflow` are tied 0.

## Structure
- **Package `pc_pkg`:** pc_sel enum (SEL_HOLD, SEL_SEQ, SEL_REDIR, SEL_RAS), the default ADDR_W and INC constants, and an alignment-mask function.
- **Sub-module `pc_ras`:** circular stack with a pointer and count. It provides push, pop and replace operations, the empty/full/overflow flags, and the top entry. It is instantiated only under `PC_GEN_RAS_EN`.

## Test plan
- **Reset:** rst=1 for 2 cycles, then rst=0 with no controls → `pc`=0 with `pc_valid`=0, then `pc_valid`=1 and `pc` sequence 4, 8, 12.
- **Stall vs redirect:** at `pc`=0x10, stall=1 for 3 cycles → `pc` holds 0x10. Then stall=1 with redirect_valid=1, `redirect_pc`=0x103 → `pc`=0x100.
- **Call/return:** at `pc`=0x20, call to 0x80 → `pc`=0x80, RAS top=0x24. At `pc`=0x84, ret → `pc`=0x24 and `ras_empty`=1.
- **Overflow:** 5 calls with RAS_DEPTH=4 → `ras_full`=1 and `ras_overflow`=1. 4 rets return the newest 4 addresses in LIFO order. A fifth ret gives `pc+4` and a one-cycle `ret_underflow` pulse.
- **Wrap:** ADDR_W=18, `pc`=0x3FFFC, no controls → `pc`=0x00000.
- **Simultaneous call and ret:** one entry 0x40, at `pc`=0x90 call_valid and ret_valid together with `redirect_pc`=0x200 → `pc`=0x200, count stays 1, top=0x94.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter generator
package pc_pkg;

   localparam int DEF_ADDR_W = 18;
   localparam int DEF_INC    = 4;

   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_REDIR,
      SEL_RAS
   } pc_sel_t;

   // Clears the byte-offset bits below the fetch granule (inc is a power of two).
   function automatic logic [63:0] align_mask(input int inc);
      return ~(64'(inc) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with push, pop and replace
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              replace,
   input  logic [ADDR_W-1:0] wdata,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     ptr;
   logic [PW:0]       count;
   logic [PW-1:0]     ptr_inc;
   logic [PW-1:0]     ptr_dec;

   assign ptr_inc = ptr + PTR_ONE;
   assign ptr_dec = ptr - PTR_ONE;

   // A push into a full stack wraps the pointer onto the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (replace) begin
         mem[ptr] <= wdata;
      end else if (push) begin
         mem[ptr_inc] <= wdata;
         ptr          <= ptr_inc;
         if (count == CNT_MAX) overflow <= 1'b1;
         else                  count    <= count + CNT_ONE;
      end else if (pop && count != '0) begin
         ptr   <= ptr_dec;
         count <= count - CNT_ONE;
      end
   end

   assign top   = mem[ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_MAX);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-fetch-address generator; return-address stack enabled by PC_GEN_RAS_EN
module pc_gen
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                INC       = DEF_INC,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              call_valid,
   input  logic              ret_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_overflow,
   output logic              ret_underflow
);

   localparam logic [63:0]       MASK64    = align_mask(INC);
   localparam logic [ADDR_W-1:0] ADDR_MASK = MASK64[ADDR_W-1:0];

   pc_sel_t           sel;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] redir_aligned;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] pc_next;

   assign pc_inc        = pc + ADDR_W'(INC);
   assign redir_aligned = redirect_pc & ADDR_MASK;

`ifdef PC_GEN_RAS_EN
   logic ras_push;
   logic ras_pop;
   logic ras_replace;
   logic underflow_next;

   always_comb begin
      sel            = SEL_SEQ;
      ras_push       = 1'b0;
      ras_pop        = 1'b0;
      ras_replace    = 1'b0;
      underflow_next = 1'b0;
      if (redirect_valid) begin
         sel = SEL_REDIR;
      end else if (stall) begin
         sel = SEL_HOLD;
      end else if (call_valid) begin
         // call+ret swaps the top entry; with nothing to swap it is a plain call
         sel = SEL_REDIR;
         if (ret_valid && !ras_empty) ras_replace = 1'b1;
         else                         ras_push    = 1'b1;
      end else if (ret_valid) begin
         if (!ras_empty) begin
            sel     = SEL_RAS;
            ras_pop = 1'b1;
         end else begin
            underflow_next = 1'b1;
         end
      end
   end

   pc_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (ras_push),
      .pop      (ras_pop),
      .replace  (ras_replace),
      .wdata    (pc_inc),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full),
      .overflow (ras_overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) ret_underflow <= 1'b0;
      else     ret_underflow <= underflow_next;
   end
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_ret;

   assign unused_ret = ret_valid;

   always_comb begin
      sel = SEL_SEQ;
      if (redirect_valid)  sel = SEL_REDIR;
      else if (stall)      sel = SEL_HOLD;
      else if (call_valid) sel = SEL_REDIR;
   end

   assign ras_top       = '0;
   assign ras_empty     = 1'b1;
   assign ras_full      = 1'b0;
   assign ras_overflow  = 1'b0;
   assign ret_underflow = 1'b0;
`endif

   always_comb begin
      pc_next = pc_inc;
      case (sel)
         SEL_HOLD:  pc_next = pc;
         SEL_SEQ:   pc_next = pc_inc;
         SEL_REDIR: pc_next = redir_aligned;
         SEL_RAS:   pc_next = ras_top;
         default:   pc_next = pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         pc_valid <= 1'b0;
      end else begin
         pc       <= pc_next;
         pc_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - vector-table and scoreboard bench for pc_gen
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [17:0] redirect_pc = '0;
   logic        call_valid = 1'b0;
   logic        ret_valid = 1'b0;
   logic [17:0] pc;
   logic        pc_valid;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;
   logic        ret_underflow;

   pc_gen #(
      .ADDR_W    (18),
      .INC       (4),
      .RESET_PC  (18'h0),
      .RAS_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .call_valid     (call_valid),
      .ret_valid      (ret_valid),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .ras_empty      (ras_empty),
      .ras_full       (ras_full),
      .ras_overflow   (ras_overflow),
      .ret_underflow  (ret_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        rv;
      logic [17:0] rpc;
      logic        call;
      logic        ret;
      logic [17:0] pc;
      logic        valid;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        und;
   } vec_t;

   typedef struct {
      logic [17:0] pc;
      logic        valid;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        und;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [17:0] rpc,
                               input logic c, input logic rt, input logic [17:0] epc, input logic ev,
                               input logic ee, input logic ef, input logic eo, input logic eu);
      vec_t v;
      v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.call = c; v.ret = rt;
      v.pc = epc; v.valid = ev; v.empty = ee; v.full = ef; v.ovf = eo; v.und = eu;
      return v;
   endfunction

   task automatic check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty when output sampled", name);
      end else begin
         e = sb.pop_front();
         vectors++;
         if ({pc, pc_valid, ras_empty, ras_full, ras_overflow, ret_underflow} !==
             {e.pc, e.valid, e.empty, e.full, e.ovf, e.und}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h v=%b e=%b f=%b o=%b u=%b, want pc=%h v=%b e=%b f=%b o=%b u=%b",
                     name, pc, pc_valid, ras_empty, ras_full, ras_overflow, ret_underflow,
                     e.pc, e.valid, e.empty, e.full, e.ovf, e.und);
         end
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      exp_t e;
      @(negedge clk);
      rst            = v.rst;
      stall          = v.stall;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      call_valid     = v.call;
      ret_valid      = v.ret;
      e.pc = v.pc; e.valid = v.valid; e.empty = v.empty;
      e.full = v.full; e.ovf = v.ovf; e.und = v.und;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(name);
   endtask

   initial begin
      // reset, sequential fetch, stall hold, redirect beating stall, alignment, wrap
      tbl.push_back(mk(1,0,0,18'h0,0,0, 18'h00000,0,1,0,0,0));
      tbl.push_back(mk(1,0,0,18'h0,0,0, 18'h00000,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00004,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00008,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h0000C,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00010,1,1,0,0,0));
      tbl.push_back(mk(0,1,0,18'h0,0,0, 18'h00010,1,1,0,0,0));
      tbl.push_back(mk(0,1,0,18'h0,0,0, 18'h00010,1,1,0,0,0));
      tbl.push_back(mk(0,1,0,18'h0,0,0, 18'h00010,1,1,0,0,0));
      tbl.push_back(mk(0,1,1,18'h103,0,0, 18'h00100,1,1,0,0,0));
      tbl.push_back(mk(0,0,1,18'h207,0,0, 18'h00204,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00208,1,1,0,0,0));
      tbl.push_back(mk(0,0,1,18'h3FFFC,0,0, 18'h3FFFC,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00000,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00004,1,1,0,0,0));
`ifdef PC_GEN_RAS_EN
      // call/return round trip, then return on an empty stack
      tbl.push_back(mk(0,0,1,18'h20,0,0, 18'h00020,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h80,1,0, 18'h00080,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00084,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00024,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00028,1,1,0,0,1));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h0002C,1,1,0,0,0));
      // five calls into a four-entry stack, then drain LIFO plus one extra ret
      tbl.push_back(mk(0,0,0,18'h100,1,0, 18'h00100,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,18'h200,1,0, 18'h00200,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,18'h300,1,0, 18'h00300,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,18'h400,1,0, 18'h00400,1,0,1,0,0));
      tbl.push_back(mk(0,0,0,18'h500,1,0, 18'h00500,1,0,1,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00404,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00304,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00204,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00104,1,1,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00108,1,1,0,1,1));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h0010C,1,1,0,1,0));
      // simultaneous call+ret replaces the top entry; stall masks ret
      tbl.push_back(mk(0,0,1,18'h3C,0,0, 18'h0003C,1,1,0,1,0));
      tbl.push_back(mk(0,0,0,18'h8C,1,0, 18'h0008C,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00090,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h200,1,1, 18'h00200,1,0,0,1,0));
      tbl.push_back(mk(0,1,0,18'h0,0,1, 18'h00200,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00094,1,1,0,1,0));
      tbl.push_back(mk(0,0,0,18'h300,1,1, 18'h00300,1,0,0,1,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00098,1,1,0,1,0));
`else
      // call acts as redirect but yields to stall; ret is ignored
      tbl.push_back(mk(0,0,0,18'h80,1,0, 18'h00080,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,1, 18'h00084,1,1,0,0,0));
      tbl.push_back(mk(0,1,0,18'h300,1,0, 18'h00084,1,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h201,1,1, 18'h00200,1,1,0,0,0));
      tbl.push_back(mk(0,1,0,18'h0,0,1, 18'h00200,1,1,0,0,0));
`endif
      // reset mid-operation, then first unreset edge
      tbl.push_back(mk(1,0,0,18'h0,0,0, 18'h00000,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,18'h0,0,0, 18'h00004,1,1,0,0,0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // held idle request advances every cycle
      for (int k = 0; k < 6; k++)
         apply(mk(0,0,0,18'h0,0,0, 18'h4 + 18'(4 * (k + 1)),1,1,0,0,0), $sformatf("seq%0d", k));

      // redirect held for several cycles keeps reloading the same target
      for (int k = 0; k < 3; k++)
         apply(mk(0,0,1,18'h1FF,0,0, 18'h001FC,1,1,0,0,0), $sformatf("hold_redir%0d", k));
      apply(mk(0,0,0,18'h0,0,0, 18'h00200,1,1,0,0,0), "after_redir");

      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
